// File: rtl/imem_fetch_controller.sv
// rtl/imem_fetch_controller.sv - PC sequencer for the synchronous instruction memory.
// Issues one read per cycle while the output FIFO has room and delivers the words to decode over valid/ready.
module imem_fetch_controller #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 1024,
    parameter int BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              halt,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              busy,
    output logic              fault
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0]       BUF_LIM = (CW + 1)'(BUF_DEPTH);
    localparam logic [ADDR_W-1:0] PC_LIM  = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;

    // Read issued last cycle: its data is on mem_rdata during this cycle.
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_pc;

    logic [DATA_W-1:0] fifo_data [BUF_DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [BUF_DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     occ;

    logic pop;
    logic flush;
    logic wr_en;
    logic space;
    logic run;
    logic issue;
    logic to_fault;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop      = (occ != '0) && inst_ready;
        flush    = redirect && (state != IDLE);
        wr_en    = rd_valid && !flush;
        space    = ({1'b0, occ} + (CW + 1)'(rd_valid)) < (BUF_LIM + (CW + 1)'(pop));
        run      = (state == FETCH) && !halt && !flush;
        issue    = run && space && (pc < PC_LIM);
        to_fault = run && space && (pc >= PC_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            fault    <= 1'b0;
            rd_valid <= 1'b0;
            rd_pc    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            rd_valid <= issue;
            rd_pc    <= pc;
            if (issue)
                pc <= pc + 1'b1;

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                occ    <= '0;
            end else begin
                if (wr_en) begin
                    fifo_data[wr_ptr] <= mem_rdata;
                    fifo_pc[wr_ptr]   <= rd_pc;
                    wr_ptr            <= ptr_inc(wr_ptr);
                end
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                occ <= occ + CW'(wr_en) - CW'(pop);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        pc    <= start_pc;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        pc    <= redirect_pc;
                        state <= halt ? IDLE : FETCH;
                    end else if (halt) begin
                        state <= IDLE;
                    end else if (to_fault) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end
                end
                FAULT: begin
                    if (redirect) begin
                        pc    <= redirect_pc;
                        fault <= 1'b0;
                        state <= halt ? IDLE : FETCH;
                    end else if (halt) begin
                        fault <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr   = pc;
    assign inst_valid = (occ != '0);
    assign inst_data  = fifo_data[rd_ptr];
    assign inst_pc    = fifo_pc[rd_ptr];
    assign busy       = (state != IDLE) || (occ != '0) || rd_valid;

endmodule

// File: tb/tb_imem_fetch_controller.sv
// tb/tb_imem_fetch_controller.sv - directed vector bench for imem_fetch_controller.
module tb_imem_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] start_pc = '0;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [63:0] mem_addr;
    logic [63:0] mem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [63:0] inst_data;
    logic [63:0] inst_pc;
    logic        busy;
    logic        fault;

    int errors = 0;
    int checks = 0;

    logic [63:0] mem [0:1023];

    imem_fetch_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_pc    (start_pc),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        mem_rdata <= (mem_addr < 64'd1024) ? mem[mem_addr[9:0]] : 64'hDEAD_DEAD;

    typedef struct {
        bit          do_rst;
        bit          start;
        logic [63:0] spc;
        bit          ready;
        bit          halt;
        bit          redir;
        logic [63:0] rpc;
        bit          ev;
        logic [63:0] epc;
        logic [63:0] edata;
        logic [63:0] eaddr;
        bit          ebusy;
        bit          efault;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 0; halt = 0; redirect = 0; inst_ready = 0;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    function automatic vec_t mk(bit r, bit s, logic [63:0] spc, bit rdy, bit h, bit rd, logic [63:0] rpc,
                                bit ev, logic [63:0] epc, logic [63:0] ed, logic [63:0] ea, bit eb, bit ef);
        vec_t v;
        v = '{r, s, spc, rdy, h, rd, rpc, ev, epc, ed, ea, eb, ef};
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++)
            mem[i] = 64'h100 + 64'(i);

        // basic stream from 0: first word valid two edges after the first issue
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0,  0,      0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,  0,      1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0,  'h100,  2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1,  'h101,  3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 2,  'h102,  4, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 3,  'h103,  5, 1, 0));
        // run off the end of memory, then redirect out of FAULT
        vecs.push_back(mk(1, 1, 1021, 1, 0, 0, 0, 0, 0,    0,     1021, 1, 0));
        vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 0, 0,    0,     1022, 1, 0));
        vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 1, 1021, 'h4FD, 1023, 1, 0));
        vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 1, 1022, 'h4FE, 1024, 1, 0));
        vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 1, 1023, 'h4FF, 1024, 1, 1));
        vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 0, 0,    0,     1024, 1, 1));
        vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 0, 0,    0,     1024, 1, 1));
        vecs.push_back(mk(0, 0, 0,    1, 0, 1, 0, 0, 0,    0,     0,    1, 0));
        vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 0, 0,    0,     1,    1, 0));
        vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 1, 0,    'h100, 2,    1, 0));

        do_reset();
        chk("reset_valid", 64'(inst_valid), 0);
        chk("reset_busy",  64'(busy), 0);
        chk("reset_fault", 64'(fault), 0);
        chk("reset_addr",  mem_addr, 0);

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) do_reset();
            start       = vecs[i].start;
            start_pc    = vecs[i].spc;
            inst_ready  = vecs[i].ready;
            halt        = vecs[i].halt;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            tick();
            chk($sformatf("v%0d_valid", i), 64'(inst_valid), 64'(vecs[i].ev));
            chk($sformatf("v%0d_addr", i),  mem_addr, vecs[i].eaddr);
            chk($sformatf("v%0d_busy", i),  64'(busy), 64'(vecs[i].ebusy));
            chk($sformatf("v%0d_fault", i), 64'(fault), 64'(vecs[i].efault));
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_pc", i),   inst_pc, vecs[i].epc);
                chk($sformatf("v%0d_data", i), inst_data, vecs[i].edata);
            end
        end
        start = 0; redirect = 0;

        // backpressure: buffer saturates at 4, stream resumes without gap or duplicate
        do_reset();
        start = 1; start_pc = 0; inst_ready = 1;
        tick();
        start = 0;
        tick();
        tick();
        inst_ready = 0;
        repeat (6) tick();
        chk("bp_addr_held", mem_addr, 4);
        chk("bp_valid", 64'(inst_valid), 1);
        chk("bp_head_pc", inst_pc, 0);
        inst_ready = 1;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp_v%0d", k), 64'(inst_valid), 1);
            chk($sformatf("bp_pc%0d", k), inst_pc, 64'(k));
            chk($sformatf("bp_d%0d", k), inst_data, 64'h100 + 64'(k));
            tick();
        end

        // redirect with words buffered and in flight
        do_reset();
        start = 1; start_pc = 0; inst_ready = 0;
        tick();
        start = 0;
        repeat (3) tick();
        chk("rd_pre_pc", inst_pc, 0);
        redirect = 1; redirect_pc = 64'h20;
        tick();
        redirect = 0;
        chk("rd_flush_valid", 64'(inst_valid), 0);
        chk("rd_flush_addr", mem_addr, 64'h20);
        chk("rd_flush_busy", 64'(busy), 1);
        inst_ready = 1;
        tick();
        chk("rd_e1_valid", 64'(inst_valid), 0);
        chk("rd_e1_addr", mem_addr, 64'h21);
        tick();
        chk("rd_e2_valid", 64'(inst_valid), 1);
        chk("rd_e2_pc", inst_pc, 64'h20);
        chk("rd_e2_data", inst_data, 64'h120);
        tick();
        chk("rd_e3_pc", inst_pc, 64'h21);
        chk("rd_e3_data", inst_data, 64'h121);

        // halt mid-stream: drain, go idle, restart
        do_reset();
        start = 1; start_pc = 0; inst_ready = 1;
        tick();
        start = 0;
        repeat (4) tick();
        chk("h_pre_pc", inst_pc, 2);
        halt = 1;
        tick();
        halt = 0;
        chk("h_e1_valid", 64'(inst_valid), 1);
        chk("h_e1_pc", inst_pc, 3);
        chk("h_e1_busy", 64'(busy), 1);
        chk("h_e1_addr", mem_addr, 4);
        tick();
        chk("h_e2_valid", 64'(inst_valid), 0);
        chk("h_e2_busy", 64'(busy), 0);
        tick();
        chk("h_e3_addr", mem_addr, 4);
        start = 1; start_pc = 64'h10;
        tick();
        start = 0;
        chk("h_rs_addr", mem_addr, 64'h10);
        tick();
        tick();
        chk("h_rs_valid", 64'(inst_valid), 1);
        chk("h_rs_pc", inst_pc, 64'h10);
        chk("h_rs_data", inst_data, 64'h110);

        // asynchronous reset while a word is presented
        #2;
        rst_n = 0;
        #1;
        chk("ar_valid", 64'(inst_valid), 0);
        chk("ar_busy", 64'(busy), 0);
        chk("ar_fault", 64'(fault), 0);
        chk("ar_addr", mem_addr, 0);
        chk("ar_pc", inst_pc, 0);
        chk("ar_data", inst_data, 0);
        tick();
        rst_n = 1;
        tick();
        chk("ar_idle_busy", 64'(busy), 0);
        chk("ar_idle_addr", mem_addr, 0);
        chk("ar_idle_valid", 64'(inst_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
